// File: rtl/systick_timer_if.sv
// Register bus between a bus master and the systick timer.
// The timer is a zero-wait-state 8-bit slave.
interface systick_timer_if;
  logic [2:0] WB_ADRi;
  logic [7:0] WB_DATi;
  logic [7:0] WB_DATo;
  logic       WB_WEi;
  logic       WB_CYCi;
  logic       WB_STBi;
  logic       WB_ACKo;

  modport master (
    output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
    input  WB_DATo, WB_ACKo
  );

  modport slave (
    input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
    output WB_DATo, WB_ACKo
  );
endinterface

// File: rtl/systick_timer.sv
// Register-programmed down-counting tick timer with an 8-bit prescaler.
// Periodic or one-shot mode, W1C pending flag and a level interrupt.
module systick_timer (
  input  logic           clk,
  input  logic           rst,
  systick_timer_if.slave bus,
  output logic           IRQ
);

  typedef enum logic [2:0] {
    A_CTRL = 3'd0,
    A_RLD0 = 3'd1,
    A_RLD1 = 3'd2,
    A_CNT0 = 3'd3,
    A_CNT1 = 3'd4,
    A_PSC  = 3'd5,
    A_STAT = 3'd6,
    A_NONE = 3'd7
  } addr_e;

  addr_e       addr;
  logic        wr;
  logic        rd;

  logic        en;
  logic        periodic;
  logic        irqen;
  logic        pend;
  logic [15:0] reload;
  logic [7:0]  psc;
  logic [15:0] count;
  logic [7:0]  pcnt;
  logic [7:0]  cnt1_shadow;

  logic        ctrl_wr;
  logic        start;
  logic        tick;
  logic        expire;

  assign addr    = addr_e'(bus.WB_ADRi);
  assign wr      = bus.WB_CYCi & bus.WB_STBi & bus.WB_WEi;
  assign rd      = bus.WB_CYCi & bus.WB_STBi & ~bus.WB_WEi;

  assign ctrl_wr = wr && (addr == A_CTRL);
  assign start   = ctrl_wr && bus.WB_DATi[7] && !en;
  // A PSC written below pcnt never matches until pcnt wraps through 0xFF.
  assign tick    = en && (pcnt == psc);
  assign expire  = tick && (count == 16'h0000);

  // Control and configuration registers.
  // NOTE: every register in a clocked process is assigned with <= so all
  // updates on an edge see the pre-edge values of the other registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      irqen    <= 1'b0;
      reload   <= 16'h0000;
      psc      <= 8'h00;
    end else begin
      if (ctrl_wr) begin
        // A bus write of EN takes precedence over the one-shot auto-stop.
        en       <= bus.WB_DATi[7];
        periodic <= bus.WB_DATi[6];
        irqen    <= bus.WB_DATi[5];
      end else if (expire && !periodic) begin
        en <= 1'b0;
      end
      if (wr && (addr == A_RLD0)) reload[7:0]  <= bus.WB_DATi;
      if (wr && (addr == A_RLD1)) reload[15:8] <= bus.WB_DATi;
      if (wr && (addr == A_PSC))  psc          <= bus.WB_DATi;
    end
  end

  // Prescaler and main down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'h0000;
      pcnt  <= 8'h00;
    end else if (start) begin
      count <= reload;
      pcnt  <= 8'h00;
    end else if (en) begin
      if (tick) begin
        pcnt <= 8'h00;
        if (count != 16'h0000) begin
          count <= count - 16'd1;
        end else if (periodic) begin
          count <= reload;
        end
      end else begin
        pcnt <= pcnt + 8'd1;
      end
    end
  end

  // Pending flag: a set on expiry wins over a same-cycle W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (expire) begin
      pend <= 1'b1;
    end else if (wr && (addr == A_STAT) && bus.WB_DATi[0]) begin
      pend <= 1'b0;
    end
  end

  // Reading CNT0 freezes the high byte so a following CNT1 read is coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1_shadow <= 8'h00;
    end else if (rd && (addr == A_CNT0)) begin
      cnt1_shadow <= count[15:8];
    end
  end

  // Read data is decoded from the address alone, also while in reset.
  // NOTE: the output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.WB_DATo = 8'h00;
    case (addr)
      A_CTRL: bus.WB_DATo = {en, periodic, irqen, 5'b00000};
      A_RLD0: bus.WB_DATo = reload[7:0];
      A_RLD1: bus.WB_DATo = reload[15:8];
      A_CNT0: bus.WB_DATo = count[7:0];
      A_CNT1: bus.WB_DATo = cnt1_shadow;
      A_PSC:  bus.WB_DATo = psc;
      A_STAT: bus.WB_DATo = {7'b0000000, pend};
      A_NONE: bus.WB_DATo = 8'h00;
      default: bus.WB_DATo = 8'h00;
    endcase
  end

  assign bus.WB_ACKo = 1'b1;
  assign IRQ         = pend & irqen;

endmodule
